controlador_temporizador: RTL and testbench

Shared-timer scheduler that owns one prescaled time base (a CLOCK divider) and lends it, one requester at a time, to up to N_REQ client blocks. Clients (dispense valve, display blink, wait-for-user timeout, etc.) each request an interval counted in slow ticks. The block grants the timer by round-robin, counts the interval on the prescaled tick and signals completion per requester. It replaces per-client free-running dividers with one arbitrated divider.

---
 rtl/controlador_temporizador.sv | 204 ++++++++++++++++++++
 tb/tb_controlador_temporizador.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/controlador_temporizador.sv
// controlador_temporizador: one prescaled time base lent round-robin to N_REQ clients.
// Each grant counts DUR slow ticks, then pulses DONE to the owner; dropping REQ aborts.
module controlador_temporizador #(
  parameter int N_REQ = 4,
  parameter int DIV   = 25_000_000,
  parameter int DUR_W = 8
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*DUR_W-1:0] DUR,
  output logic [N_REQ-1:0]       GNT,
  output logic [N_REQ-1:0]       DONE,
  output logic                   TICK,
  output logic                   BUSY,
  output logic [DUR_W-1:0]       REMAIN
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] PTR_RST  = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [IW-1:0]      ptr_r, ptr_nxt_s;
  logic [PW-1:0]      pre_r, pre_nxt_s;
  logic [N_REQ-1:0]   gnt_r, gnt_nxt_s;
  logic [N_REQ-1:0]   done_r, done_nxt_s;
  logic               tick_r, tick_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic [DUR_W-1:0]   remain_r, remain_nxt_s;

  logic [DUR_W-1:0]   dur_arr_s [N_REQ];
  logic [IW-1:0]      win_s;
  logic [DUR_W-1:0]   win_dur_s;
  logic               own_req_s;

  // Round-robin search starting just after the last owner, wrapping mod N_REQ.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [IW-1:0]    ptr);
    logic [IW-1:0] pick;
    logic          hit;
    int            idx;
    pick = ptr;
    hit  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!hit && req[IW'(idx)]) begin
        pick = IW'(idx);
        hit  = 1'b1;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_dur
    assign dur_arr_s[g] = DUR[g*DUR_W +: DUR_W];
  end

  // Arbitration candidate and the owner's live request level.
  always_comb begin
    win_s     = rr_pick(REQ, ptr_r);
    win_dur_s = dur_arr_s[win_s];
    own_req_s = REQ[ptr_r];
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt_s  = state_r;
    ptr_nxt_s    = ptr_r;
    pre_nxt_s    = pre_r;
    gnt_nxt_s    = gnt_r;
    done_nxt_s   = '0;
    tick_nxt_s   = 1'b0;
    busy_nxt_s   = busy_r;
    remain_nxt_s = remain_r;
    case (state_r)
      ST_IDLE: begin
        if (|REQ) begin
          ptr_nxt_s    = win_s;
          pre_nxt_s    = '0;
          gnt_nxt_s    = onehot(win_s);
          busy_nxt_s   = 1'b1;
          remain_nxt_s = win_dur_s;
          state_nxt_s  = (win_dur_s == '0) ? ST_FIN : ST_RUN;
        end else begin
          gnt_nxt_s    = '0;
          busy_nxt_s   = 1'b0;
          remain_nxt_s = '0;
        end
      end
      ST_RUN: begin
        // Abort takes precedence over a final tick landing on the same edge.
        if (!own_req_s) begin
          pre_nxt_s    = '0;
          gnt_nxt_s    = '0;
          busy_nxt_s   = 1'b0;
          remain_nxt_s = '0;
          state_nxt_s  = ST_IDLE;
        end else if (pre_r == PRE_LAST) begin
          pre_nxt_s    = '0;
          tick_nxt_s   = 1'b1;
          remain_nxt_s = remain_r - DUR_W'(1);
          state_nxt_s  = (remain_r == DUR_W'(1)) ? ST_FIN : ST_RUN;
        end else begin
          pre_nxt_s    = pre_r + PW'(1);
        end
      end
      ST_FIN: begin
        if (!own_req_s) begin
          done_nxt_s = '0;
        end else begin
          done_nxt_s = onehot(ptr_r);
        end
        pre_nxt_s    = '0;
        gnt_nxt_s    = '0;
        busy_nxt_s   = 1'b0;
        remain_nxt_s = '0;
        state_nxt_s  = ST_IDLE;
      end
      default: begin
        pre_nxt_s    = '0;
        gnt_nxt_s    = '0;
        busy_nxt_s   = 1'b0;
        remain_nxt_s = '0;
        state_nxt_s  = ST_IDLE;
      end
    endcase
  end

  // State, pointer, prescaler and output registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r  <= ST_IDLE;
      ptr_r    <= PTR_RST;
      pre_r    <= '0;
      gnt_r    <= '0;
      done_r   <= '0;
      tick_r   <= 1'b0;
      busy_r   <= 1'b0;
      remain_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      ptr_r    <= ptr_nxt_s;
      pre_r    <= pre_nxt_s;
      gnt_r    <= gnt_nxt_s;
      done_r   <= done_nxt_s;
      tick_r   <= tick_nxt_s;
      busy_r   <= busy_nxt_s;
      remain_r <= remain_nxt_s;
    end
  end

  assign GNT    = gnt_r;
  assign DONE   = done_r;
  assign TICK   = tick_r;
  assign BUSY   = busy_r;
  assign REMAIN = remain_r;

endmodule

// controlador_temporizador_chk: structural invariants of the timer outputs.
module controlador_temporizador_chk #(
  parameter int N_REQ = 4,
  parameter int DUR_W = 8
) (
  input logic             CLOCK,
  input logic             RESET_N,
  input logic [N_REQ-1:0] GNT,
  input logic [N_REQ-1:0] DONE,
  input logic             TICK,
  input logic             BUSY,
  input logic [DUR_W-1:0] REMAIN
);

  // Sampled each rising edge while out of reset.
  always @(posedge CLOCK) begin
    if (RESET_N) begin
      assert ($onehot0(GNT));
      assert ($onehot0(DONE));
      assert (BUSY == (|GNT));
      assert (!((|GNT) && (|DONE)));
      assert (BUSY || ((REMAIN == '0) && !TICK));
    end
  end

endmodule

// File: tb/tb_controlador_temporizador.sv
// Directed bench for controlador_temporizador with DIV=4, four clients, 8-bit durations.
module tb_controlador_temporizador;

  localparam int NR     = 4;
  localparam int TB_DIV = 4;
  localparam int DW     = 8;

  logic            CLOCK = 1'b0;
  logic            RESET_N;
  logic [NR-1:0]   REQ;
  logic [NR*DW-1:0] DUR;
  logic [NR-1:0]   GNT;
  logic [NR-1:0]   DONE;
  logic            TICK;
  logic            BUSY;
  logic [DW-1:0]   REMAIN;

  int err_cnt = 0;
  int chk_cnt = 0;

  controlador_temporizador #(.N_REQ(NR), .DIV(TB_DIV), .DUR_W(DW)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .REQ(REQ), .DUR(DUR),
    .GNT(GNT), .DONE(DONE), .TICK(TICK), .BUSY(BUSY), .REMAIN(REMAIN)
  );

  controlador_temporizador_chk #(.N_REQ(NR), .DUR_W(DW)) chk (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .GNT(GNT), .DONE(DONE),
    .TICK(TICK), .BUSY(BUSY), .REMAIN(REMAIN)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_dur(input int idx, input int val);
    DUR[idx*DW +: DW] = DW'(val);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, " gnt"}, 32'(GNT), 32'd0);
    check_val({tag, " done"}, 32'(DONE), 32'd0);
    check_val({tag, " tick"}, 32'(TICK), 32'd0);
    check_val({tag, " busy"}, 32'(BUSY), 32'd0);
    check_val({tag, " remain"}, 32'(REMAIN), 32'd0);
  endtask

  // Starts at the sample just after the grant edge; ends at the DONE sample.
  task automatic watch_grant(input int cl, input int dur);
    logic [NR-1:0] oh;
    int            ticks;
    oh    = 4'b0001 << cl;
    ticks = 0;
    check_val($sformatf("cl%0d gnt c0", cl), 32'(GNT), 32'(oh));
    check_val($sformatf("cl%0d busy c0", cl), 32'(BUSY), 32'd1);
    check_val($sformatf("cl%0d remain c0", cl), 32'(REMAIN), 32'(dur));
    check_val($sformatf("cl%0d tick c0", cl), 32'(TICK), 32'd0);
    check_val($sformatf("cl%0d done c0", cl), 32'(DONE), 32'd0);
    for (int c = 1; c <= dur * TB_DIV + 1; c++) begin
      step();
      if (c <= dur * TB_DIV) begin
        check_val($sformatf("cl%0d gnt c%0d", cl, c), 32'(GNT), 32'(oh));
        check_val($sformatf("cl%0d tick c%0d", cl, c), 32'(TICK), 32'((c % TB_DIV) == 0));
        check_val($sformatf("cl%0d remain c%0d", cl, c), 32'(REMAIN), 32'(dur - c / TB_DIV));
        check_val($sformatf("cl%0d done c%0d", cl, c), 32'(DONE), 32'd0);
        ticks += int'(TICK);
      end else begin
        check_val($sformatf("cl%0d done pulse", cl), 32'(DONE), 32'(oh));
        check_val($sformatf("cl%0d gnt off", cl), 32'(GNT), 32'd0);
        check_val($sformatf("cl%0d busy off", cl), 32'(BUSY), 32'd0);
        check_val($sformatf("cl%0d remain off", cl), 32'(REMAIN), 32'd0);
        check_val($sformatf("cl%0d tick off", cl), 32'(TICK), 32'd0);
      end
    end
    check_val($sformatf("cl%0d tick count", cl), 32'(ticks), 32'(dur));
  endtask

  initial begin
    RESET_N = 1'b0;
    REQ     = '0;
    DUR     = '0;
    #3;
    check_idle_outputs("por");
    #9;
    RESET_N = 1'b1;
    step();
    check_idle_outputs("idle after reset");

    // Asynchronous reset in the middle of a running interval
    REQ = 4'b0001;
    set_dur(0, 3);
    step();
    check_val("pre-reset gnt", 32'(GNT), 32'b0001);
    check_val("pre-reset remain", 32'(REMAIN), 32'd3);
    repeat (4) step();
    check_val("pre-reset tick", 32'(TICK), 32'd1);
    check_val("pre-reset remain2", 32'(REMAIN), 32'd2);
    repeat (2) step();
    #2;
    RESET_N = 1'b0;
    #1;
    check_idle_outputs("async reset");
    #2;
    RESET_N = 1'b1;
    step();
    watch_grant(0, 3);
    REQ = '0;
    step();
    check_idle_outputs("idle A");

    // Single interval on client 1; DUR change after grant is ignored
    REQ = 4'b0010;
    set_dur(1, 3);
    step();
    set_dur(1, 7);
    watch_grant(1, 3);
    REQ = '0;
    step();
    check_idle_outputs("idle B");

    // Zero duration on client 2
    REQ = 4'b0100;
    set_dur(2, 0);
    step();
    watch_grant(2, 0);
    REQ = '0;
    step();
    check_idle_outputs("idle C");

    // Abort client 3 after two ticks while client 0 waits
    REQ = 4'b1000;
    set_dur(3, 5);
    set_dur(0, 1);
    step();
    check_val("abort gnt", 32'(GNT), 32'b1000);
    check_val("abort remain0", 32'(REMAIN), 32'd5);
    repeat (4) step();
    check_val("abort tick1", 32'(TICK), 32'd1);
    check_val("abort remain1", 32'(REMAIN), 32'd4);
    repeat (4) step();
    check_val("abort tick2", 32'(TICK), 32'd1);
    check_val("abort remain2", 32'(REMAIN), 32'd3);
    REQ = 4'b0001;
    step();
    check_idle_outputs("aborted");
    step();
    watch_grant(0, 1);
    REQ = '0;
    step();
    check_idle_outputs("idle D");

    // Abort on the edge that would carry the final tick
    REQ = 4'b0100;
    set_dur(2, 1);
    step();
    check_val("late abort gnt", 32'(GNT), 32'b0100);
    repeat (3) step();
    check_val("late abort remain", 32'(REMAIN), 32'd1);
    check_val("late abort tick pre", 32'(TICK), 32'd0);
    REQ = '0;
    step();
    check_idle_outputs("late abort");
    step();
    check_idle_outputs("late abort no done");

    // Wrap priority: pointer at 3, REQ=1001 serves 0 before 3, new DUR[3] used
    REQ = 4'b1000;
    set_dur(3, 1);
    step();
    watch_grant(3, 1);
    REQ = 4'b1001;
    set_dur(0, 1);
    set_dur(3, 2);
    step();
    set_dur(3, 4);
    watch_grant(0, 1);
    REQ = 4'b1000;
    step();
    watch_grant(3, 4);

    // Round robin with all clients requesting, DUR=1 each
    REQ = 4'b1111;
    for (int i = 0; i < NR; i++) set_dur(i, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      watch_grant(i % NR, 1);
      if (i == 4) REQ = '0;
      step();
    end
    check_idle_outputs("idle F");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
